dili_stream_bridge: RTL and testbench

//  Parametrised job engine between the host register interface and a

---
 rtl/dili_stream_bridge.sv | 160 ++++++++++++++++
 tb/tb_dili_stream_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dili_stream_bridge.sv
// dili_stream_bridge: job engine that streams buffered host words to a Dilithium
// DUT over valid/ready and buffers the DUT results for host readback.
//
//   state    | meaning
//   ST_IDLE  | after reset/clear, waiting for start_i
//   ST_RUN   | feeding input words to the DUT, results may already return
//   ST_DRAIN | all input words sent, collecting remaining results
//   ST_DONE  | job complete, FIFO contents kept, start_i launches next job
module dili_stream_bridge #(
    parameter int pW      = 64,
    parameter int pOUT_W  = 92,
    parameter int pIN_AW  = 4,
    parameter int pOUT_AW = 4,
    parameter int pCNT_W  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic [15:0]         in_count_i,
    input  logic [15:0]         out_count_i,
    input  logic                host_wr_i,
    input  logic [pW-1:0]       host_wdata_i,
    input  logic                host_rd_i,
    output logic [pOUT_W-1:0]   host_rdata_o,
    output logic [pIN_AW:0]     in_level_o,
    output logic [pOUT_AW:0]    out_level_o,
    output logic                dut_valid_o,
    output logic [pW-1:0]       dut_data_o,
    input  logic                dut_ready_i,
    input  logic                dut_valid_i,
    input  logic [pOUT_W-1:0]   dut_data_i,
    output logic                dut_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                trigger_o,
    output logic [pCNT_W-1:0]   cycle_cnt_o,
    output logic                overflow_o,
    output logic                underflow_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int IN_DEPTH  = 2 ** pIN_AW;
    localparam int OUT_DEPTH = 2 ** pOUT_AW;
    localparam logic [pIN_AW:0]  IN_FULL  = {1'b1, {pIN_AW{1'b0}}};
    localparam logic [pOUT_AW:0] OUT_FULL = {1'b1, {pOUT_AW{1'b0}}};

    logic [1:0]          r_state;
    logic [15:0]         r_in_cnt, r_out_cnt, r_sent, r_got;
    logic [pCNT_W-1:0]   r_cyc;
    logic                r_trig, r_ovf, r_unf;

    logic [pW-1:0]       r_in_mem [IN_DEPTH];
    logic [pIN_AW-1:0]   r_in_wp, r_in_rp;
    logic [pIN_AW:0]     r_in_lvl;
    logic [pOUT_W-1:0]   r_out_mem [OUT_DEPTH];
    logic [pOUT_AW-1:0]  r_out_wp, r_out_rp;
    logic [pOUT_AW:0]    r_out_lvl;

    logic w_rst, w_run, w_busy;
    logic w_in_push, w_in_pop, w_out_push, w_out_pop;

    // clear_i is a full synchronous re-initialisation, identical to reset
    assign w_rst      = !resetn || clear_i;
    assign w_run      = (r_state == ST_RUN);
    assign w_busy     = w_run || (r_state == ST_DRAIN);

    assign dut_valid_o = w_run && (r_in_lvl != '0) && (r_sent < r_in_cnt);
    assign dut_ready_o = w_busy && (r_out_lvl != OUT_FULL) && (r_got < r_out_cnt);

    // Full/empty decided on registered levels: no write-through on a full FIFO
    assign w_in_push  = host_wr_i && (r_in_lvl != IN_FULL);
    assign w_in_pop   = dut_valid_o && dut_ready_i;
    assign w_out_push = dut_valid_i && dut_ready_o;
    assign w_out_pop  = host_rd_i && (r_out_lvl != '0);

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_in_lvl <= '0;
            for (int i = 0; i < IN_DEPTH; i++) r_in_mem[i] <= '0;
        end else begin
            if (w_in_push) begin
                r_in_mem[r_in_wp] <= host_wdata_i;
                r_in_wp           <= r_in_wp + pIN_AW'(1);
            end
            if (w_in_pop) r_in_rp <= r_in_rp + pIN_AW'(1);
            if (w_in_push && !w_in_pop)      r_in_lvl <= r_in_lvl + (pIN_AW+1)'(1);
            else if (!w_in_push && w_in_pop) r_in_lvl <= r_in_lvl - (pIN_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_lvl <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) r_out_mem[i] <= '0;
        end else begin
            if (w_out_push) begin
                r_out_mem[r_out_wp] <= dut_data_i;
                r_out_wp            <= r_out_wp + pOUT_AW'(1);
            end
            if (w_out_pop) r_out_rp <= r_out_rp + pOUT_AW'(1);
            if (w_out_push && !w_out_pop)      r_out_lvl <= r_out_lvl + (pOUT_AW+1)'(1);
            else if (!w_out_push && w_out_pop) r_out_lvl <= r_out_lvl - (pOUT_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state   <= ST_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sent    <= '0;
            r_got     <= '0;
            r_cyc     <= '0;
            r_trig    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_trig <= w_busy;
            if (host_wr_i && !w_in_push)      r_ovf <= 1'b1;
            if (host_rd_i && (r_out_lvl == '0)) r_unf <= 1'b1;
            if (w_in_pop)   r_sent <= r_sent + 16'd1;
            if (w_out_push) r_got  <= r_got + 16'd1;
            if (w_busy && (r_cyc != '1)) r_cyc <= r_cyc + pCNT_W'(1);
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_state   <= ST_RUN;
                        r_in_cnt  <= in_count_i;
                        r_out_cnt <= out_count_i;
                        r_sent    <= '0;
                        r_got     <= '0;
                        r_cyc     <= '0;
                    end
                end
                ST_RUN:   if (r_sent == r_in_cnt) r_state <= ST_DRAIN;
                ST_DRAIN: if (r_got == r_out_cnt) r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_rdata_o = r_out_mem[r_out_rp];
    assign dut_data_o   = r_in_mem[r_in_rp];
    assign in_level_o   = r_in_lvl;
    assign out_level_o  = r_out_lvl;
    assign busy_o       = w_busy;
    assign done_o       = (r_state == ST_DONE);
    assign trigger_o    = r_trig;
    assign cycle_cnt_o  = r_cyc;
    assign overflow_o   = r_ovf;
    assign underflow_o  = r_unf;
endmodule

// File: tb/tb_dili_stream_bridge.sv
// Directed testbench for dili_stream_bridge: host-side jobs against a
// scripted DUT responder, with hand-computed expectations.
module tb_dili_stream_bridge;
    localparam int pW = 64, pOUT_W = 92, pIN_AW = 4, pOUT_AW = 4, pCNT_W = 32;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                start_i = 1'b0, clear_i = 1'b0;
    logic [15:0]         in_count_i = '0, out_count_i = '0;
    logic                host_wr_i = 1'b0;
    logic [pW-1:0]       host_wdata_i = '0;
    logic                host_rd_i = 1'b0;
    logic [pOUT_W-1:0]   host_rdata_o;
    logic [pIN_AW:0]     in_level_o;
    logic [pOUT_AW:0]    out_level_o;
    logic                dut_valid_o;
    logic [pW-1:0]       dut_data_o;
    logic                dut_ready_i = 1'b0;
    logic                dut_valid_i = 1'b0;
    logic [pOUT_W-1:0]   dut_data_i = '0;
    logic                dut_ready_o;
    logic                busy_o, done_o, trigger_o;
    logic [pCNT_W-1:0]   cycle_cnt_o;
    logic                overflow_o, underflow_o;

    int n_cmp = 0, n_err = 0;
    bit dut_rdy = 1'b1;
    logic [pW-1:0]     seen_q[$];
    logic [pOUT_W-1:0] rsp_q[$];

    dili_stream_bridge #(.pW(pW), .pOUT_W(pOUT_W), .pIN_AW(pIN_AW), .pOUT_AW(pOUT_AW), .pCNT_W(pCNT_W)) u_dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .clear_i(clear_i),
        .in_count_i(in_count_i), .out_count_i(out_count_i),
        .host_wr_i(host_wr_i), .host_wdata_i(host_wdata_i), .host_rd_i(host_rd_i),
        .host_rdata_o(host_rdata_o), .in_level_o(in_level_o), .out_level_o(out_level_o),
        .dut_valid_o(dut_valid_o), .dut_data_o(dut_data_o), .dut_ready_i(dut_ready_i),
        .dut_valid_i(dut_valid_i), .dut_data_i(dut_data_i), .dut_ready_o(dut_ready_o),
        .busy_o(busy_o), .done_o(done_o), .trigger_o(trigger_o), .cycle_cnt_o(cycle_cnt_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: present the responder's head word, log transfers due at the edge.
    task automatic step();
        dut_ready_i = dut_rdy;
        if (rsp_q.size() > 0) begin
            dut_valid_i = 1'b1;
            dut_data_i  = rsp_q[0];
        end else begin
            dut_valid_i = 1'b0;
            dut_data_i  = '0;
        end
        #1;
        if (dut_valid_o && dut_ready_i) seen_q.push_back(dut_data_o);
        if (dut_valid_i && dut_ready_o) void'(rsp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [pW-1:0] d);
        host_wr_i = 1'b1; host_wdata_i = d;
        step();
        host_wr_i = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [pOUT_W-1:0] exp);
        check_val(tag, host_rdata_o, exp);
        host_rd_i = 1'b1;
        step();
        host_rd_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] n_in, input logic [15:0] n_out);
        in_count_i = n_in; out_count_i = n_out; start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            step();
            n++;
        end
        check_val(tag, done_o, 1'b1);
    endtask

    task automatic check_seen(input string tag, input int n, input logic [pW-1:0] base, input logic [pW-1:0] inc);
        check_val({tag, "_cnt"}, seen_q.size(), n);
        for (int i = 0; i < n && i < seen_q.size(); i++)
            check_val({tag, "_word"}, seen_q[i], base + inc * i);
        seen_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_in_lvl", in_level_o, 0);
        check_val("rst_out_lvl", out_level_o, 0);
        check_val("rst_rdata", host_rdata_o, 0);
        check_val("rst_dvalid", dut_valid_o, 0);
        check_val("rst_dready", dut_ready_o, 0);
        check_val("rst_cyc", cycle_cnt_o, 0);
        check_val("rst_trig", trigger_o, 0);
        check_val("rst_flags", {overflow_o, underflow_o}, 0);
        resetn = 1'b1;
        step();

        // T1: four words in, two results back
        for (int i = 1; i <= 4; i++) host_write(64'(i));
        check_val("t1_in_lvl", in_level_o, 4);
        check_val("t1_idle_valid", dut_valid_o, 0);
        rsp_q.push_back(92'hA);
        rsp_q.push_back(92'hB);
        pulse_start(16'd4, 16'd2);
        check_val("t1_busy", busy_o, 1);
        check_val("t1_trig_lag", trigger_o, 0);
        run_until_done("t1_done", 30);
        check_seen("t1_seen", 4, 64'h1, 64'h1);
        check_val("t1_cyc", cycle_cnt_o, 6);
        check_val("t1_trig_done", trigger_o, 1);
        check_val("t1_out_lvl", out_level_o, 2);
        host_read("t1_rd0", 92'hA);
        host_read("t1_rd1", 92'hB);
        check_val("t1_trig_fall", trigger_o, 0);
        check_val("t1_cyc_hold", cycle_cnt_o, 6);
        check_val("t1_out_empty", out_level_o, 0);

        // T2: input starves mid-job
        host_write(64'h11);
        pulse_start(16'd3, 16'd0);
        repeat (10) step();
        check_val("t2_busy", busy_o, 1);
        check_val("t2_not_done", done_o, 0);
        check_val("t2_starved", dut_valid_o, 0);
        host_write(64'h22);
        host_write(64'h33);
        run_until_done("t2_done", 20);
        check_seen("t2_seen", 3, 64'h11, 64'h11);
        check_val("t2_cyc", cycle_cnt_o, 15);

        // T3: more results than output FIFO depth, host not reading
        for (int i = 0; i < 20; i++) rsp_q.push_back(92'(32'h100 + i));
        pulse_start(16'd0, 16'd20);
        for (int n = 0; n < 40 && out_level_o != 16; n++) step();
        check_val("t3_full", out_level_o, 16);
        check_val("t3_backpress", dut_ready_o, 0);
        repeat (3) step();
        check_val("t3_full_hold", out_level_o, 16);
        check_val("t3_pending", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++) host_read("t3_rd_a", 92'(32'h100 + i));
        run_until_done("t3_done", 30);
        check_val("t3_all_taken", rsp_q.size(), 0);
        check_val("t3_lvl_after", out_level_o, 16);
        for (int i = 0; i < 16; i++) host_read("t3_rd_b", 92'(32'h104 + i));
        check_val("t3_out_empty", out_level_o, 0);

        // T4: 17 writes into a 16-deep input FIFO
        for (int i = 0; i < 16; i++) host_write(64'(32'h200 + i));
        check_val("t4_lvl16", in_level_o, 16);
        check_val("t4_no_ovf", overflow_o, 0);
        host_write(64'hDEAD);
        check_val("t4_lvl_hold", in_level_o, 16);
        check_val("t4_ovf", overflow_o, 1);
        check_val("t4_head_kept", dut_data_o, 64'h200);
        pulse_clear();
        check_val("t4_clr_ovf", overflow_o, 0);
        check_val("t4_clr_lvl", in_level_o, 0);
        check_val("t4_clr_idle", done_o, 0);
        check_val("t4_clr_head", dut_data_o, 0);

        // T5: read of empty output FIFO
        host_rd_i = 1'b1;
        step();
        host_rd_i = 1'b0;
        check_val("t5_unf", underflow_o, 1);
        check_val("t5_rdata", host_rdata_o, 0);
        check_val("t5_lvl", out_level_o, 0);
        pulse_clear();
        check_val("t5_clr_unf", underflow_o, 0);

        // T6: reset while draining, then a full job
        host_write(64'h44);
        rsp_q.push_back(92'h99);
        pulse_start(16'd1, 16'd2);
        repeat (5) step();
        check_val("t6_drain_busy", busy_o, 1);
        check_val("t6_drain_lvl", out_level_o, 1);
        check_val("t6_drain_done", done_o, 0);
        seen_q.delete();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_val("t6_rst_busy", busy_o, 0);
        check_val("t6_rst_done", done_o, 0);
        check_val("t6_rst_lvls", {in_level_o, out_level_o}, 0);
        check_val("t6_rst_cyc", cycle_cnt_o, 0);
        host_write(64'h55);
        host_write(64'h66);
        rsp_q.push_back(92'h77);
        pulse_start(16'd2, 16'd1);
        run_until_done("t6_done", 30);
        check_seen("t6_seen", 2, 64'h55, 64'h11);
        host_read("t6_rd", 92'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
